// File: rtl/seg_cfg_bank.sv
// -----------------------------------------------------------------------------
// seg_cfg_bank
//
// Segment configuration bank for the modulation / STM sequencers. Each channel
// holds NUM_SEGMENTS shadow sets of (CYCLE, FREQ_DIV, REP). The controller
// register decode path writes these sets. A control write selects one segment.
// That segment is then copied into the channel's live registers, either on the
// next cycle (immediate) or after the next SYNC_TICK (deferred). Each channel
// counts LOOP_END pulses against its live REP and raises STOPPED once the
// repetitions are used up.
//
// Optional feature macro: SEG_CFG_READBACK_EN
//   defined   : DOUT returns the addressed shadow field (or channel status for
//               field 7). DOUT has one cycle of latency from RD_ADDR.
//   undefined : DOUT is tied to zero and RD_ADDR is ignored.
//
// Ports
//   CLK         system clock
//   RST_N       asynchronous active-low reset
//   WE          write strobe, one word per cycle
//   ADDR[7:0]   {ch[1:0], seg[2:0], field[2:0]} write address
//   DIN[15:0]   write data
//   RD_ADDR     readback address, same layout as ADDR
//   DOUT        readback data
//   SYNC_TICK   one-cycle pulse that releases deferred commits
//   LOOP_END    per channel: one full pass of the active segment finished
//   CYCLE       live cycle, NUM_CHANNELS x CYCLE_WIDTH
//   FREQ_DIV    live frequency divider, NUM_CHANNELS x 32
//   REP         live repetition count, NUM_CHANNELS x 32
//   ACTIVE_SEG  live segment index, NUM_CHANNELS x 3
//   UPDATE      per channel: one-cycle strobe while a commit is applied
//   PENDING     per channel: deferred commit waiting for SYNC_TICK
//   STOPPED     per channel: repetitions exhausted
//
// Field map: 0 CYCLE, 1 FREQ_DIV[15:0], 2 FREQ_DIV[31:16], 3 REP[15:0],
//            4 REP[31:16], 7 CTL (DIN[2:0] segment, DIN[8] immediate).
// -----------------------------------------------------------------------------
module seg_cfg_bank #(
    parameter int NUM_CHANNELS = 2,
    parameter int NUM_SEGMENTS = 2,
    parameter int CYCLE_WIDTH  = 16
) (
    input  logic                                CLK,
    input  logic                                RST_N,
    input  logic                                WE,
    input  logic [7:0]                          ADDR,
    input  logic [15:0]                         DIN,
    input  logic [7:0]                          RD_ADDR,
    output logic [15:0]                         DOUT,
    input  logic                                SYNC_TICK,
    input  logic [NUM_CHANNELS-1:0]             LOOP_END,
    output logic [NUM_CHANNELS*CYCLE_WIDTH-1:0] CYCLE,
    output logic [NUM_CHANNELS*32-1:0]          FREQ_DIV,
    output logic [NUM_CHANNELS*32-1:0]          REP,
    output logic [NUM_CHANNELS*3-1:0]           ACTIVE_SEG,
    output logic [NUM_CHANNELS-1:0]             UPDATE,
    output logic [NUM_CHANNELS-1:0]             PENDING,
    output logic [NUM_CHANNELS-1:0]             STOPPED
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    // ---------------------------------------------------------------- decode
    logic [1:0] wr_ch;
    logic [2:0] wr_seg;
    logic [2:0] wr_fld;
    logic       wr_ch_ok;
    logic       wr_seg_ok;
    logic       ctl_wr;

    assign wr_ch     = ADDR[7:6];
    assign wr_seg    = ADDR[5:3];
    assign wr_fld    = ADDR[2:0];
    assign wr_ch_ok  = (32'(wr_ch) < NUM_CHANNELS);
    assign wr_seg_ok = (32'(wr_seg) < NUM_SEGMENTS);
    // A control write ignores the segment bits of ADDR. It is dropped when the
    // requested segment does not exist.
    assign ctl_wr    = WE && (wr_fld == 3'd7) && wr_ch_ok
                       && (32'(DIN[2:0]) < NUM_SEGMENTS);

    // ------------------------------------------------------- shadow storage
    // The arrays are sized to the full 2-bit / 3-bit address space so the
    // address fields can index them directly. Out-of-range entries are never
    // written, so they stay at their reset value of zero.
    logic [CYCLE_WIDTH-1:0] sh_cycle_q [4][8];
    logic [CYCLE_WIDTH-1:0] sh_cycle_d [4][8];
    logic [31:0]            sh_freq_q  [4][8];
    logic [31:0]            sh_freq_d  [4][8];
    logic [31:0]            sh_rep_q   [4][8];
    logic [31:0]            sh_rep_d   [4][8];

    always_comb begin
        sh_cycle_d = sh_cycle_q;
        sh_freq_d  = sh_freq_q;
        sh_rep_d   = sh_rep_q;
        if (WE && wr_ch_ok && wr_seg_ok) begin
            case (wr_fld)
                3'd0:    sh_cycle_d[wr_ch][wr_seg]       = DIN[CYCLE_WIDTH-1:0];
                3'd1:    sh_freq_d[wr_ch][wr_seg][15:0]  = DIN;
                3'd2:    sh_freq_d[wr_ch][wr_seg][31:16] = DIN;
                3'd3:    sh_rep_d[wr_ch][wr_seg][15:0]   = DIN;
                3'd4:    sh_rep_d[wr_ch][wr_seg][31:16]  = DIN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int c = 0; c < 4; c++) begin
                for (int s = 0; s < 8; s++) begin
                    sh_cycle_q[c][s] <= '0;
                    sh_freq_q[c][s]  <= '0;
                    sh_rep_q[c][s]   <= '0;
                end
            end
        end else begin
            sh_cycle_q <= sh_cycle_d;
            sh_freq_q  <= sh_freq_d;
            sh_rep_q   <= sh_rep_d;
        end
    end

    // ---------------------------------------------------- per-channel logic
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            state_t                 state_q, state_d;
            logic [2:0]             req_q, req_d;
            logic [2:0]             seg_q, seg_d;
            logic [CYCLE_WIDTH-1:0] cyc_q, cyc_d;
            logic [31:0]            freq_q, freq_d;
            logic [31:0]            rep_q, rep_d;
            logic [31:0]            cnt_q, cnt_d;
            logic                   stopped_q, stopped_d;
            logic                   ctl_hit;

            assign ctl_hit = ctl_wr && (wr_ch == 2'(gi));

            // Commit sequencing. A control write in APPLY is treated the same
            // as one in IDLE. A control write in WAIT only replaces the request.
            always_comb begin
                state_d = state_q;
                req_d   = req_q;
                case (state_q)
                    ST_IDLE, ST_APPLY: begin
                        if (ctl_hit) begin
                            req_d   = DIN[2:0];
                            state_d = DIN[8] ? ST_APPLY : ST_WAIT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_WAIT: begin
                        if (ctl_hit) begin
                            req_d = DIN[2:0];
                        end else if (SYNC_TICK) begin
                            state_d = ST_APPLY;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            // Live copy and repetition tracking.
            always_comb begin
                cyc_d     = cyc_q;
                freq_d    = freq_q;
                rep_d     = rep_q;
                seg_d     = seg_q;
                cnt_d     = cnt_q;
                stopped_d = stopped_q;
                if (state_q == ST_APPLY) begin
                    cyc_d     = sh_cycle_q[gi][req_q];
                    freq_d    = sh_freq_q[gi][req_q];
                    rep_d     = sh_rep_q[gi][req_q];
                    seg_d     = req_q;
                    cnt_d     = '0;
                    stopped_d = 1'b0;
                end else if (LOOP_END[gi] && !stopped_q
                             && (rep_q != 32'hFFFF_FFFF)) begin
                    cnt_d = cnt_q + 32'd1;
                    // The count reaching REP+1 means it was equal to REP before
                    // this increment. This check avoids a 33-bit compare.
                    if (cnt_q == rep_q) begin
                        stopped_d = 1'b1;
                    end
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    state_q   <= ST_IDLE;
                    req_q     <= '0;
                    seg_q     <= '0;
                    cyc_q     <= '0;
                    freq_q    <= '0;
                    rep_q     <= '0;
                    cnt_q     <= '0;
                    stopped_q <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    req_q     <= req_d;
                    seg_q     <= seg_d;
                    cyc_q     <= cyc_d;
                    freq_q    <= freq_d;
                    rep_q     <= rep_d;
                    cnt_q     <= cnt_d;
                    stopped_q <= stopped_d;
                end
            end

            assign CYCLE[gi*CYCLE_WIDTH +: CYCLE_WIDTH] = cyc_q;
            assign FREQ_DIV[gi*32 +: 32]                = freq_q;
            assign REP[gi*32 +: 32]                     = rep_q;
            assign ACTIVE_SEG[gi*3 +: 3]                = seg_q;
            assign UPDATE[gi]                           = (state_q == ST_APPLY);
            assign PENDING[gi]                          = (state_q == ST_WAIT);
            assign STOPPED[gi]                          = stopped_q;
        end
    endgenerate

    // ------------------------------------------------------------- readback
`ifdef SEG_CFG_READBACK_EN
    logic [1:0]  rd_ch;
    logic [2:0]  rd_seg;
    logic [2:0]  rd_fld;
    logic [15:0] dout_q, dout_d;

    assign rd_ch  = RD_ADDR[7:6];
    assign rd_seg = RD_ADDR[5:3];
    assign rd_fld = RD_ADDR[2:0];

    always_comb begin
        dout_d = '0;
        if (32'(rd_ch) < NUM_CHANNELS) begin
            if (rd_fld == 3'd7) begin
                // Status word. The segment bits of RD_ADDR are ignored, as
                // they are for control writes.
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    if (rd_ch == 2'(c)) begin
                        dout_d = {7'b0, PENDING[c], 5'b0, ACTIVE_SEG[c*3 +: 3]};
                    end
                end
            end else if (32'(rd_seg) < NUM_SEGMENTS) begin
                case (rd_fld)
                    3'd0:    dout_d = 16'(sh_cycle_q[rd_ch][rd_seg]);
                    3'd1:    dout_d = sh_freq_q[rd_ch][rd_seg][15:0];
                    3'd2:    dout_d = sh_freq_q[rd_ch][rd_seg][31:16];
                    3'd3:    dout_d = sh_rep_q[rd_ch][rd_seg][15:0];
                    3'd4:    dout_d = sh_rep_q[rd_ch][rd_seg][31:16];
                    default: dout_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign DOUT = dout_q;
`else
    logic rd_addr_unused;
    assign rd_addr_unused = ^RD_ADDR;
    assign DOUT           = '0;
`endif

endmodule

// File: tb/tb_seg_cfg_bank.sv
// -----------------------------------------------------------------------------
// tb_seg_cfg_bank
//
// Self-checking bench for seg_cfg_bank with two channels and two segments.
// A behavioural model tracks the shadow sets, the commit requests, the live
// copies and the loop counts. The bench compares it against every DUT output
// after every clock. Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_seg_cfg_bank;

    localparam int NCH  = 2;
    localparam int NSEG = 2;
    localparam int CW   = 16;

    logic                CLK       = 1'b0;
    logic                RST_N     = 1'b0;
    logic                WE        = 1'b0;
    logic [7:0]          ADDR      = '0;
    logic [15:0]         DIN       = '0;
    logic [7:0]          RD_ADDR   = '0;
    logic                SYNC_TICK = 1'b0;
    logic [NCH-1:0]      LOOP_END  = '0;
    logic [15:0]         DOUT;
    logic [NCH*CW-1:0]   CYCLE;
    logic [NCH*32-1:0]   FREQ_DIV;
    logic [NCH*32-1:0]   REP;
    logic [NCH*3-1:0]    ACTIVE_SEG;
    logic [NCH-1:0]      UPDATE;
    logic [NCH-1:0]      PENDING;
    logic [NCH-1:0]      STOPPED;

    seg_cfg_bank #(
        .NUM_CHANNELS (NCH),
        .NUM_SEGMENTS (NSEG),
        .CYCLE_WIDTH  (CW)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .WE         (WE),
        .ADDR       (ADDR),
        .DIN        (DIN),
        .RD_ADDR    (RD_ADDR),
        .DOUT       (DOUT),
        .SYNC_TICK  (SYNC_TICK),
        .LOOP_END   (LOOP_END),
        .CYCLE      (CYCLE),
        .FREQ_DIV   (FREQ_DIV),
        .REP        (REP),
        .ACTIVE_SEG (ACTIVE_SEG),
        .UPDATE     (UPDATE),
        .PENDING    (PENDING),
        .STOPPED    (STOPPED)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------- model
    logic [15:0] m_sh_cyc  [4][8];
    logic [31:0] m_sh_freq [4][8];
    logic [31:0] m_sh_rep  [4][8];
    logic [15:0] m_cyc     [NCH];
    logic [31:0] m_freq    [NCH];
    logic [31:0] m_rep     [NCH];
    logic [2:0]  m_seg     [NCH];
    logic [2:0]  m_req     [NCH];
    logic [63:0] m_loops   [NCH];
    bit          m_stopped [NCH];
    bit          m_pending [NCH];
    bit          m_update  [NCH];
    logic [15:0] m_dout;

    task automatic model_reset();
        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 8; s++) begin
                m_sh_cyc[c][s]  = '0;
                m_sh_freq[c][s] = '0;
                m_sh_rep[c][s]  = '0;
            end
        for (int c = 0; c < NCH; c++) begin
            m_cyc[c] = '0; m_freq[c] = '0; m_rep[c] = '0; m_seg[c] = '0;
            m_req[c] = '0; m_loops[c] = '0; m_stopped[c] = 0;
            m_pending[c] = 0; m_update[c] = 0;
        end
        m_dout = '0;
    endtask

    // One rising edge. The inputs are still held at their sampled values.
    task automatic model_step();
        int  wc, ws, wf, rc, rs, rf;
        bit  ctl_ok;
        wc = int'(ADDR[7:6]);    ws = int'(ADDR[5:3]);    wf = int'(ADDR[2:0]);
        rc = int'(RD_ADDR[7:6]); rs = int'(RD_ADDR[5:3]); rf = int'(RD_ADDR[2:0]);
        m_dout = '0;
`ifdef SEG_CFG_READBACK_EN
        if (rc < NCH) begin
            if (rf == 7) m_dout = {7'b0, m_pending[rc], 5'b0, m_seg[rc]};
            else if (rs < NSEG) begin
                case (rf)
                    0: m_dout = m_sh_cyc[rc][rs];
                    1: m_dout = m_sh_freq[rc][rs][15:0];
                    2: m_dout = m_sh_freq[rc][rs][31:16];
                    3: m_dout = m_sh_rep[rc][rs][15:0];
                    4: m_dout = m_sh_rep[rc][rs][31:16];
                    default: m_dout = '0;
                endcase
            end
        end
`endif
        ctl_ok = WE && (wf == 7) && (wc < NCH) && (int'(DIN[2:0]) < NSEG);
        for (int c = 0; c < NCH; c++) begin
            if (m_update[c]) begin
                m_cyc[c]     = m_sh_cyc[c][m_req[c]];
                m_freq[c]    = m_sh_freq[c][m_req[c]];
                m_rep[c]     = m_sh_rep[c][m_req[c]];
                m_seg[c]     = m_req[c];
                m_loops[c]   = '0;
                m_stopped[c] = 0;
            end else if (LOOP_END[c] && !m_stopped[c] && m_rep[c] != 32'hFFFF_FFFF) begin
                m_loops[c] = m_loops[c] + 64'd1;
                if (m_loops[c] == {32'b0, m_rep[c]} + 64'd1) m_stopped[c] = 1;
            end
            if (ctl_ok && wc == c) begin
                m_req[c] = DIN[2:0];
                if (m_pending[c]) m_update[c] = 0;
                else if (DIN[8]) begin m_update[c] = 1; m_pending[c] = 0; end
                else begin m_pending[c] = 1; m_update[c] = 0; end
            end else if (m_pending[c] && SYNC_TICK) begin
                m_pending[c] = 0;
                m_update[c]  = 1;
            end else begin
                m_update[c] = 0;
            end
        end
        if (WE && wc < NCH && ws < NSEG) begin
            case (wf)
                0: m_sh_cyc[wc][ws]         = DIN;
                1: m_sh_freq[wc][ws][15:0]  = DIN;
                2: m_sh_freq[wc][ws][31:16] = DIN;
                3: m_sh_rep[wc][ws][15:0]   = DIN;
                4: m_sh_rep[wc][ws][31:16]  = DIN;
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            check_eq($sformatf("update%0d", c),  64'(UPDATE[c]),  64'(m_update[c]));
            check_eq($sformatf("pending%0d", c), 64'(PENDING[c]), 64'(m_pending[c]));
            check_eq($sformatf("stopped%0d", c), 64'(STOPPED[c]), 64'(m_stopped[c]));
            check_eq($sformatf("aseg%0d", c),    64'(ACTIVE_SEG[c*3 +: 3]), 64'(m_seg[c]));
            check_eq($sformatf("cycle%0d", c),   64'(CYCLE[c*CW +: CW]),    64'(m_cyc[c]));
            check_eq($sformatf("freq%0d", c),    64'(FREQ_DIV[c*32 +: 32]), 64'(m_freq[c]));
            check_eq($sformatf("rep%0d", c),     64'(REP[c*32 +: 32]),      64'(m_rep[c]));
        end
        check_eq("dout", 64'(DOUT), 64'(m_dout));
    endtask

    task automatic cycle();
        @(posedge CLK);
        if (!RST_N) model_reset();
        else        model_step();
        #1;
        check_all();
    endtask

    task automatic wr(input int ch, input int seg, input int fld, input logic [15:0] d);
        logic [1:0] c2;
        logic [2:0] s3, f3;
        c2 = ch[1:0]; s3 = seg[2:0]; f3 = fld[2:0];
        $display("wr ch=%0d seg=%0d fld=%0d data=0x%04h", ch, seg, fld, d);
        ADDR = {c2, s3, f3};
        DIN  = d;
        WE   = 1'b1;
        cycle();
        WE   = 1'b0;
    endtask

    // ----------------------------------------------------------- stimulus
    initial begin
        int upd_cnt;
        model_reset();
        repeat (3) cycle();
        check_eq("rst_update", 64'(UPDATE), 64'd0);
        check_eq("rst_aseg", 64'(ACTIVE_SEG), 64'd0);
        check_eq("rst_dout", 64'(DOUT), 64'd0);
        RST_N = 1'b1;
        cycle();

        // Immediate commit of channel 0, segment 1.
        wr(0, 1, 0, 16'h00FF);
        wr(0, 1, 1, 16'h0000);
        wr(0, 1, 2, 16'h0001);
        wr(0, 1, 3, 16'h0003);
        wr(0, 1, 4, 16'h0000);
        wr(0, 0, 7, 16'h0101);
        check_eq("imm_update", 64'(UPDATE[0]), 64'd1);
        check_eq("imm_live_not_yet", 64'(ACTIVE_SEG[2:0]), 64'd0);
        cycle();
        check_eq("imm_update_one_cycle", 64'(UPDATE[0]), 64'd0);
        check_eq("imm_aseg", 64'(ACTIVE_SEG[2:0]), 64'd1);
        check_eq("imm_cycle", 64'(CYCLE[15:0]), 64'h00FF);
        check_eq("imm_freq", 64'(FREQ_DIV[31:0]), 64'h0001_0000);

        // REP=3: STOPPED after the 4th LOOP_END. The 5th is ignored.
        for (int k = 1; k <= 5; k++) begin
            $display("loop_end ch=0 n=%0d", k);
            LOOP_END = 2'b01;
            cycle();
            LOOP_END = 2'b00;
            check_eq($sformatf("stop_after_%0d", k), 64'(STOPPED[0]), 64'(k >= 4));
        end

        // Deferred commit of channel 1.
        wr(1, 1, 0, 16'h1234);
        wr(1, 0, 7, 16'h0001);
        check_eq("def_pending_n1", 64'(PENDING[1]), 64'd1);
        for (int k = 0; k < 10; k++) begin
            cycle();
            check_eq("def_pending_hold", 64'(PENDING[1]), 64'd1);
            check_eq("def_no_update", 64'(UPDATE[1]), 64'd0);
        end
        $display("sync_tick");
        SYNC_TICK = 1'b1;
        cycle();
        SYNC_TICK = 1'b0;
        check_eq("def_update", 64'(UPDATE[1]), 64'd1);
        check_eq("def_pending_clr", 64'(PENDING[1]), 64'd0);
        cycle();
        check_eq("def_aseg", 64'(ACTIVE_SEG[5:3]), 64'd1);
        check_eq("def_cycle", 64'(CYCLE[31:16]), 64'h1234);

        // Latest deferred request wins, and only one UPDATE follows.
        wr(0, 0, 7, 16'h0001);
        wr(0, 0, 7, 16'h0000);
        cycle();
        SYNC_TICK = 1'b1;
        cycle();
        SYNC_TICK = 1'b0;
        upd_cnt = int'(UPDATE[0]);
        for (int k = 0; k < 4; k++) begin
            cycle();
            upd_cnt += int'(UPDATE[0]);
        end
        check_eq("latest_single_update", 64'(upd_cnt), 64'd1);
        check_eq("latest_aseg", 64'(ACTIVE_SEG[2:0]), 64'd0);

        // Infinite repetitions on both channels, committed on adjacent cycles.
        wr(0, 0, 3, 16'hFFFF);
        wr(0, 0, 4, 16'hFFFF);
        wr(1, 0, 3, 16'hFFFF);
        wr(1, 0, 4, 16'hFFFF);
        wr(0, 0, 7, 16'h0100);
        check_eq("adj_update0", 64'(UPDATE[0]), 64'd1);
        wr(1, 0, 7, 16'h0100);
        check_eq("adj_update1", 64'(UPDATE[1]), 64'd1);
        check_eq("adj_update0_done", 64'(UPDATE[0]), 64'd0);
        cycle();
        LOOP_END = 2'b11;
        repeat (100) cycle();
        LOOP_END = 2'b00;
        check_eq("inf_not_stopped", 64'(STOPPED), 64'd0);
        check_eq("inf_rep", 64'(REP[31:0]), 64'hFFFF_FFFF);

        // A request for a segment that does not exist is dropped.
        wr(0, 0, 7, 16'h0105);
        check_eq("bad_seg_no_update", 64'(UPDATE[0]), 64'd0);
        check_eq("bad_seg_no_pending", 64'(PENDING[0]), 64'd0);

        // Readback of a shadow field.
        wr(0, 1, 1, 16'hABCD);
        RD_ADDR = 8'b00_001_001;
        cycle();
`ifdef SEG_CFG_READBACK_EN
        check_eq("rd_freq_lo", 64'(DOUT), 64'hABCD);
`else
        check_eq("rd_tied_zero", 64'(DOUT), 64'd0);
`endif
        RD_ADDR = '0;

        // REP=0: the first LOOP_END stops the channel. A LOOP_END during
        // the APPLY cycle does not count.
        wr(1, 0, 3, 16'h0000);
        wr(1, 0, 4, 16'h0000);
        wr(1, 0, 7, 16'h0100);
        LOOP_END = 2'b10;
        cycle();
        LOOP_END = 2'b00;
        check_eq("apply_loop_ignored", 64'(STOPPED[1]), 64'd0);
        LOOP_END = 2'b10;
        cycle();
        LOOP_END = 2'b00;
        check_eq("rep0_stopped", 64'(STOPPED[1]), 64'd1);

        // Reset while a commit is pending aborts it.
        wr(1, 0, 7, 16'h0001);
        check_eq("abort_pending", 64'(PENDING[1]), 64'd1);
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        check_eq("abort_pending_clr", 64'(PENDING[1]), 64'd0);
        cycle();
        RST_N = 1'b1;
        SYNC_TICK = 1'b1;
        cycle();
        SYNC_TICK = 1'b0;
        check_eq("abort_no_update", 64'(UPDATE[1]), 64'd0);

        // Randomized traffic checked against the model every cycle.
        for (int n = 0; n < 1500; n++) begin
            WE      = ($urandom_range(0, 2) != 0);
            ADDR    = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ADDR[2:0] = 3'd7;
            DIN     = 16'($urandom);
            if (ADDR[2:0] == 3'd7) DIN[2:0] = 3'($urandom_range(0, 2));
            if (ADDR[2:0] == 3'd3) DIN = 16'($urandom_range(0, 3));
            if (ADDR[2:0] == 3'd4) DIN = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'h0000;
            SYNC_TICK = ($urandom_range(0, 5) == 0);
            LOOP_END  = 2'($urandom);
            RD_ADDR   = 8'($urandom);
            if (WE) $display("rnd wr addr=0x%02h data=0x%04h tick=%0b loop=%b",
                             ADDR, DIN, SYNC_TICK, LOOP_END);
            cycle();
        end
        WE = 1'b0; SYNC_TICK = 1'b0; LOOP_END = '0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
